// File: rtl/agc_mdt_injector.sv
// Host-side monitor-data injector: waits for a target AGC timepulse, then drives MDT/MONPAR for one timepulse window.
// Optional MDT_GEN_PARITY_EN: generate odd parity over the word instead of passing IN_PAR through.
module agc_mdt_injector #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        MT01,
  input  logic        MT02,
  input  logic        MT03,
  input  logic        MT04,
  input  logic        MT05,
  input  logic        MT06,
  input  logic        MT07,
  input  logic        MT08,
  input  logic        MT09,
  input  logic        MT10,
  input  logic        MT11,
  input  logic        MT12,
  input  logic        MGOJAM,
  input  logic [15:0] IN_WORD,
  input  logic        IN_PAR,
  input  logic [3:0]  IN_TP,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        MDT01,
  output logic        MDT02,
  output logic        MDT03,
  output logic        MDT04,
  output logic        MDT05,
  output logic        MDT06,
  output logic        MDT07,
  output logic        MDT08,
  output logic        MDT09,
  output logic        MDT10,
  output logic        MDT11,
  output logic        MDT12,
  output logic        MDT13,
  output logic        MDT14,
  output logic        MDT15,
  output logic        MDT16,
  output logic        MONPAR,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [11:0] mt, mt_prev, rise;
  logic [11:0] tp_sel, next_sel;
  logic        rise_tp, rise_next, tp_legal, par_in, accept;
  logic [15:0] word_q, word_nxt;
  logic        par_q, par_nxt;
  logic [3:0]  tp_q, tp_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] mdt_q, mdt_nxt;
  logic        monpar_q, monpar_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        ready_q, ready_nxt;

  assign mt = {MT12, MT11, MT10, MT09, MT08, MT07, MT06, MT05, MT04, MT03, MT02, MT01};

  // A level already high on the previous cycle is never treated as a new edge.
  assign rise = mt & ~mt_prev;

  // tp_q is only meaningful outside IDLE, where it is always 1..12.
  assign tp_sel    = 12'd1 << (tp_q - 4'd1);
  assign next_sel  = (tp_q == 4'd12) ? 12'd1 : (tp_sel << 1);
  assign rise_tp   = |(rise & tp_sel);
  assign rise_next = |(rise & next_sel);

  assign tp_legal = (IN_TP >= 4'd1) && (IN_TP <= 4'd12);
  assign accept   = IN_VALID && ready_q;

`ifdef MDT_GEN_PARITY_EN
  assign par_in = ~^IN_WORD;
`else
  assign par_in = IN_PAR;
`endif

  always_comb begin
    state_nxt  = state;
    word_nxt   = word_q;
    par_nxt    = par_q;
    tp_nxt     = tp_q;
    cnt_nxt    = cnt_q;
    mdt_nxt    = mdt_q;
    monpar_nxt = monpar_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          word_nxt = IN_WORD;
          par_nxt  = par_in;
          tp_nxt   = IN_TP;
          if (tp_legal) begin
            state_nxt = S_ARMED;
            cnt_nxt   = 16'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (MGOJAM) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (rise_tp) begin
          state_nxt  = S_DRIVE;
          mdt_nxt    = word_q;
          monpar_nxt = par_q;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      S_DRIVE: begin
        // GOJAM outranks a simultaneous end-of-window edge.
        if (MGOJAM) begin
          state_nxt  = S_IDLE;
          mdt_nxt    = 16'd0;
          monpar_nxt = 1'b0;
          err_nxt    = 1'b1;
        end else if (rise_next) begin
          state_nxt  = S_IDLE;
          mdt_nxt    = 16'd0;
          monpar_nxt = 1'b0;
          done_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        mdt_nxt    = 16'd0;
        monpar_nxt = 1'b0;
      end
    endcase

    ready_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST) begin
      state    <= S_IDLE;
      mt_prev  <= 12'd0;
      word_q   <= 16'd0;
      par_q    <= 1'b0;
      tp_q     <= 4'd0;
      cnt_q    <= 16'd0;
      mdt_q    <= 16'd0;
      monpar_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      mt_prev  <= mt;
      word_q   <= word_nxt;
      par_q    <= par_nxt;
      tp_q     <= tp_nxt;
      cnt_q    <= cnt_nxt;
      mdt_q    <= mdt_nxt;
      monpar_q <= monpar_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      ready_q  <= ready_nxt;
    end
  end

  assign IN_READY = ready_q;
  assign MONPAR   = monpar_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

  assign MDT01 = mdt_q[0];
  assign MDT02 = mdt_q[1];
  assign MDT03 = mdt_q[2];
  assign MDT04 = mdt_q[3];
  assign MDT05 = mdt_q[4];
  assign MDT06 = mdt_q[5];
  assign MDT07 = mdt_q[6];
  assign MDT08 = mdt_q[7];
  assign MDT09 = mdt_q[8];
  assign MDT10 = mdt_q[9];
  assign MDT11 = mdt_q[10];
  assign MDT12 = mdt_q[11];
  assign MDT13 = mdt_q[12];
  assign MDT14 = mdt_q[13];
  assign MDT15 = mdt_q[14];
  assign MDT16 = mdt_q[15];

endmodule

// File: tb/tb_agc_mdt_injector.sv
// Directed bench for agc_mdt_injector (TIMEOUT=16); MT lines are driven explicitly as a one-hot vector.
module tb_agc_mdt_injector;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST;
  logic [11:0] mt;
  logic        MGOJAM;
  logic [15:0] IN_WORD;
  logic        IN_PAR;
  logic [3:0]  IN_TP;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] mdt;
  logic        MONPAR, DONE, ERR;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  agc_mdt_injector #(.TIMEOUT(16)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
    .MT01(mt[0]), .MT02(mt[1]), .MT03(mt[2]), .MT04(mt[3]),
    .MT05(mt[4]), .MT06(mt[5]), .MT07(mt[6]), .MT08(mt[7]),
    .MT09(mt[8]), .MT10(mt[9]), .MT11(mt[10]), .MT12(mt[11]),
    .MGOJAM(MGOJAM), .IN_WORD(IN_WORD), .IN_PAR(IN_PAR), .IN_TP(IN_TP),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .MDT01(mdt[0]), .MDT02(mdt[1]), .MDT03(mdt[2]), .MDT04(mdt[3]),
    .MDT05(mdt[4]), .MDT06(mdt[5]), .MDT07(mdt[6]), .MDT08(mdt[7]),
    .MDT09(mdt[8]), .MDT10(mdt[9]), .MDT11(mdt[10]), .MDT12(mdt[11]),
    .MDT13(mdt[12]), .MDT14(mdt[13]), .MDT15(mdt[14]), .MDT16(mdt[15]),
    .MONPAR(MONPAR), .DONE(DONE), .ERR(ERR)
  );

  always @(negedge SYS_CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (ERR === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [15:0] w, input logic p);
`ifdef MDT_GEN_PARITY_EN
    exp_par = ~^w;
`else
    exp_par = p;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  function automatic logic [11:0] onehot(input int k);
    logic [11:0] v;
    v = 12'd0;
    if (k >= 1 && k <= 12) v[k-1] = 1'b1;
    return v;
  endfunction

  // One accepting edge; the caller is left just after that edge.
  task automatic accept(input logic [15:0] w, input logic [3:0] tp, input logic p);
    IN_WORD  = w;
    IN_TP    = tp;
    IN_PAR   = p;
    IN_VALID = 1'b1;
    step(1);
    IN_VALID = 1'b0;
  endtask

  initial begin
    SYS_RST = 1'b0; mt = 12'd0; MGOJAM = 1'b0;
    IN_WORD = 16'd0; IN_PAR = 1'b0; IN_TP = 4'd0; IN_VALID = 1'b0;

    // Reset state
    step(2);
    check("rst_ready", IN_READY, 1);
    check("rst_mdt", mdt, 0);
    check("rst_monpar", MONPAR, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    SYS_RST = 1'b1;
    step(1);

    // Basic injection: word 0x1234 on MT03, window ends at MT04
    mt = onehot(2);
    step(3);
    accept(16'h1234, 4'd3, 1'b0);
    check("basic_ready_drop", IN_READY, 0);
    step(4);
    check("basic_mdt_armed", mdt, 0);
    mt = onehot(3);
    step(1);
    check("basic_mdt_drive", mdt, 32'h1234);
    check("basic_monpar", MONPAR, exp_par(16'h1234, 1'b0));
    step(7);
    check("basic_mdt_hold", mdt, 32'h1234);
    check("basic_done_early", DONE, 0);
    mt = onehot(4);
    step(1);
    check("basic_mdt_end", mdt, 0);
    check("basic_done", DONE, 1);
    check("basic_ready_back", IN_READY, 1);
    step(1);
    check("basic_done_low", DONE, 0);

    // Wrap-around: MT12 target, window closes on MT01
    mt = onehot(11);
    accept(16'hFFFF, 4'd12, 1'b1);
    step(1);
    mt = onehot(12);
    step(1);
    check("wrap_mdt_drive", mdt, 32'hFFFF);
    check("wrap_monpar", MONPAR, exp_par(16'hFFFF, 1'b1));
    step(3);
    mt = onehot(1);
    step(1);
    check("wrap_mdt_end", mdt, 0);
    check("wrap_done", DONE, 1);

    // Timeout with MT quiet: ERR exactly 16 edges after accept
    mt = 12'd0;
    step(1);
    accept(16'hBEEF, 4'd5, 1'b1);
    step(15);
    check("tmo_err_early", ERR, 0);
    check("tmo_ready_early", IN_READY, 0);
    step(1);
    check("tmo_err", ERR, 1);
    check("tmo_ready", IN_READY, 1);
    check("tmo_mdt", mdt, 0);
    step(1);
    check("tmo_err_low", ERR, 0);

    // Illegal timepulses, back-to-back requests
    IN_WORD = 16'h7777; IN_PAR = 1'b1; IN_TP = 4'd0; IN_VALID = 1'b1;
    step(1);
    check("ill0_err", ERR, 1);
    check("ill0_ready", IN_READY, 1);
    IN_TP = 4'd13;
    step(1);
    check("ill13_err", ERR, 1);
    check("ill13_ready", IN_READY, 1);
    check("ill13_mdt", mdt, 0);
    IN_VALID = 1'b0;
    step(1);
    check("ill_err_low", ERR, 0);

    // GOJAM during drive
    mt = onehot(5);
    accept(16'hA5A5, 4'd6, 1'b1);
    mt = onehot(6);
    step(1);
    check("gj_mdt_drive", mdt, 32'hA5A5);
    check("gj_monpar_drive", MONPAR, exp_par(16'hA5A5, 1'b1));
    step(2);
    MGOJAM = 1'b1;
    step(1);
    check("gj_mdt", mdt, 0);
    check("gj_monpar", MONPAR, 0);
    check("gj_err", ERR, 1);
    check("gj_done", DONE, 0);
    MGOJAM = 1'b0;
    mt = onehot(7);
    step(1);
    check("gj_done_after", DONE, 0);
    check("gj_err_low", ERR, 0);

    // GOJAM coincident with the closing edge
    accept(16'h0F0F, 4'd8, 1'b0);
    mt = onehot(8);
    step(1);
    check("gjx_mdt_drive", mdt, 32'h0F0F);
    mt = onehot(9);
    MGOJAM = 1'b1;
    step(1);
    check("gjx_err", ERR, 1);
    check("gjx_done", DONE, 0);
    check("gjx_mdt", mdt, 0);
    MGOJAM = 1'b0;
    step(1);

    // Reset mid-drive, then no false edge from MT04 already high
    mt = onehot(3);
    accept(16'h5A5A, 4'd4, 1'b0);
    mt = onehot(4);
    step(1);
    check("rd_mdt_drive", mdt, 32'h5A5A);
    step(1);
    SYS_RST = 1'b0;
    step(1);
    check("rd_mdt", mdt, 0);
    check("rd_monpar", MONPAR, 0);
    check("rd_ready", IN_READY, 1);
    check("rd_done", DONE, 0);
    check("rd_err", ERR, 0);
    SYS_RST = 1'b1;
    accept(16'h5A5A, 4'd4, 1'b1);
    step(3);
    check("rd_no_spurious", mdt, 0);
    check("rd_still_armed", IN_READY, 0);
    mt = 12'd0;
    step(1);
    mt = onehot(4);
    step(1);
    check("rd_mdt_real", mdt, 32'h5A5A);
    check("rd_monpar_real", MONPAR, exp_par(16'h5A5A, 1'b1));
    mt = onehot(5);
    step(1);
    check("rd_done_real", DONE, 1);
    check("rd_mdt_end", mdt, 0);
    step(2);

    check("total_done", done_cnt, 3);
    check("total_err", err_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
